// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spart_pkg
// Purpose  : Shared state encoding, I/O addresses and baud divisors
// Revision : 1.0 - initial release
// ============================================================================
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO  = 3'd0,
        CFG_HI  = 3'd1,
        IDLE    = 3'd2,
        RD      = 3'd3,
        RD_DROP = 3'd4,
        WR      = 3'd5,
        GUARD   = 3'd6
    } state_t;

    localparam logic [1:0] DATA   = 2'b00;
    localparam logic [1:0] DIV_LO = 2'b10;
    localparam logic [1:0] DIV_HI = 2'b11;

    // 100 MHz clock, 16x oversampling
    localparam logic [15:0] DIV_4800  = 16'h0515;
    localparam logic [15:0] DIV_9600  = 16'h028A;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A2;

    function automatic logic [15:0] baud_div(input logic [1:0] sel);
        logic [15:0] div;
        case (sel)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_driver_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : echo_fifo
// Purpose  : Small synchronous byte FIFO buffering received bytes for echo
// Revision : 1.0 - initial release
// ============================================================================
module echo_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
// Module   : spart_driver
// Purpose  : SPART bus master - programs the baud divisor, then echoes RX bytes
// Revision : 1.0 - initial release
// ============================================================================
module spart_driver
    import spart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] rx_count,
    output logic       ovf
);

    state_t      r_state;
    state_t      w_next;
    logic        r_iocs;
    logic        r_iorw;
    logic [1:0]  r_ioaddr;
    logic [1:0]  r_br;
    logic        r_pend;
    logic [15:0] r_div;

    logic        w_change;
    logic        w_nx_cs;
    logic        w_nx_rw;
    logic [1:0]  w_nx_addr;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [7:0]  w_wdata;

    assign w_change = (r_br != br_cfg);

    always_comb begin
        w_next = r_state;
        case (r_state)
            // Reset leaves iocs low in CFG_LO; the first free cycle issues the write.
            CFG_LO:          w_next = r_iocs ? CFG_HI : CFG_LO;
            CFG_HI:          w_next = GUARD;
            IDLE: begin
                if (r_pend || w_change)  w_next = CFG_LO;
                else if (rda && !w_full) w_next = RD;
                else if (!w_empty && tbr) w_next = WR;
                else if (rda)            w_next = RD_DROP;
                else                     w_next = IDLE;
            end
            RD, RD_DROP, WR: w_next = GUARD;
            GUARD:           w_next = IDLE;
            default:         w_next = CFG_LO;
        endcase

        w_nx_cs   = 1'b0;
        w_nx_rw   = 1'b1;
        w_nx_addr = DATA;
        case (w_next)
            CFG_LO: begin
                w_nx_cs   = 1'b1;
                w_nx_rw   = 1'b0;
                w_nx_addr = DIV_LO;
            end
            CFG_HI: begin
                w_nx_cs   = 1'b1;
                w_nx_rw   = 1'b0;
                w_nx_addr = DIV_HI;
            end
            RD, RD_DROP: begin
                w_nx_cs   = 1'b1;
            end
            WR: begin
                w_nx_cs   = 1'b1;
                w_nx_rw   = 1'b0;
            end
            default: begin
                w_nx_cs   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= CFG_LO;
            r_iocs   <= 1'b0;
            r_iorw   <= 1'b1;
            r_ioaddr <= DATA;
            r_br     <= br_cfg;
            r_pend   <= 1'b0;
            r_div    <= baud_div(br_cfg);
            rx_count <= 8'd0;
            ovf      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_iocs   <= w_nx_cs;
            r_iorw   <= w_nx_rw;
            r_ioaddr <= w_nx_addr;
            r_br     <= br_cfg;
            r_pend   <= (w_next != CFG_LO) && (r_pend || w_change);
            if (w_next == CFG_LO) begin
                r_div <= baud_div(br_cfg);
            end
            if (r_state == RD || r_state == RD_DROP) begin
                rx_count <= rx_count + 8'd1;
            end
            if (r_state == RD_DROP) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        case (r_state)
            CFG_LO:  w_wdata = r_div[7:0];
            CFG_HI:  w_wdata = r_div[15:8];
            default: w_wdata = w_head;
        endcase
    end

    assign iocs    = r_iocs;
    assign iorw    = r_iorw;
    assign ioaddr  = r_ioaddr;
    assign databus = (r_iocs && !r_iorw) ? w_wdata : 8'bzzzz_zzzz;

    echo_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_echo_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_state == RD),
        .pop   (r_state == WR),
        .din   (databus),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_spart_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spart_driver
// Purpose  : Self-checking bench for spart_driver with a model SPART and FIFO
// Revision : 1.0 - initial release
// ============================================================================
module tb_spart_driver;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] rx_count;
    logic       ovf;
    logic [7:0] spart_rx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] c;
        logic        rw;
        logic [1:0]  a;
        logic [7:0]  d;
    } bus_t;

    bus_t       mon_q[$];
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    int         m_rx;
    logic       m_ovf;
    logic [15:0] div_tab [4];

    spart_driver #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .rda      (rda),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rx_count (rx_count),
        .ovf      (ovf)
    );

    // The SPART owns the bus whenever the driver signals a read.
    assign databus = iorw ? spart_rx : 8'bzzzz_zzzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        bus_t t;
        if (iocs) begin
            t.c  = 32'(cyc);
            t.rw = iorw;
            t.a  = ioaddr;
            t.d  = databus;
            mon_q.push_back(t);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_rx(input logic [7:0] b);
        m_rx++;
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic expect_acc(input string tag, input logic rw, input logic [1:0] a,
                              input logic [7:0] d, output int c);
        int   w;
        bus_t t;
        w = 0;
        c = -1;
        while (mon_q.size() == 0 && w < 60) begin
            tick();
            w++;
        end
        if (mon_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed no access expected access within 60 cycles", tag);
        end else begin
            t = mon_q.pop_front();
            c = int'(t.c);
            chk(tag, {21'd0, t.rw, t.a, t.d}, {21'd0, rw, a, d});
        end
    endtask

    // Presents a byte with rda until the driver reads it; optionally moves br_cfg mid-read.
    task automatic send(input logic [7:0] b, input logic chg, input logic [1:0] nb);
        int   w;
        logic seen;
        w = 0;
        seen = 1'b0;
        spart_rx = b;
        rda = 1'b1;
        while (!seen && w < 60) begin
            @(negedge clk);
            w++;
            seen = iocs && iorw && (ioaddr == 2'b00);
        end
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL rd_wait: observed no read expected read of %0h", b);
        end
        if (chg) br_cfg = nb;
        tick();
        rda = 1'b0;
    endtask

    initial begin : stim
        int         c0;
        int         c1;
        int         cp;
        int         rel;
        logic [7:0] b;
        logic [7:0] b2;
        logic [7:0] e;
        bus_t       t;

        div_tab[0] = 16'h0515;
        div_tab[1] = 16'h028A;
        div_tab[2] = 16'h0145;
        div_tab[3] = 16'h00A2;
        m_rx = 0;
        m_ovf = 1'b0;
        rst = 1'b0;
        br_cfg = 2'b01;
        rda = 1'b0;
        tbr = 1'b0;
        spart_rx = 8'hEE;

        // Reset values
        repeat (3) tick();
        chk("rst_iocs", {31'd0, iocs}, 32'd0);
        chk("rst_iorw", {31'd0, iorw}, 32'd1);
        chk("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
        chk("rst_rx_count", {24'd0, rx_count}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_bus_z", {24'd0, databus}, {24'd0, spart_rx});
        mon_q.delete();

        // Divisor programming after release
        rst = 1'b1;
        rel = cyc;
        expect_acc("cfg_lo", 1'b0, 2'b10, div_tab[1][7:0], c0);
        chk("cfg_lo_cycle", 32'(c0), 32'(rel + 1));
        expect_acc("cfg_hi", 1'b0, 2'b11, div_tab[1][15:8], c1);
        chk("cfg_hi_cycle", 32'(c1), 32'(rel + 2));
        repeat (3) tick();
        chk("idle_iocs", {31'd0, iocs}, 32'd0);
        chk("idle_bus_z", {24'd0, databus}, {24'd0, spart_rx});

        // Basic echo and its latency
        tbr = 1'b1;
        send(8'h41, 1'b0, 2'b00);
        model_rx(8'h41);
        expect_acc("echo_rd", 1'b1, 2'b00, 8'h41, c0);
        e = mq.pop_front();
        expect_acc("echo_wr", 1'b0, 2'b00, e, c1);
        chk("echo_latency", 32'(c1 - c0), 32'd3);
        chk("echo_rx_count", {24'd0, rx_count}, 32'(m_rx));

        // Overflow with transmitter blocked
        tbr = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            b = 8'h10 + 8'(i);
            send(b, 1'b0, 2'b00);
            model_rx(b);
            expect_acc("ovf_rd", 1'b1, 2'b00, b, c0);
        end
        repeat (3) tick();
        chk("ovf_flag", {31'd0, ovf}, {31'd0, m_ovf});
        chk("ovf_rx_count", {24'd0, rx_count}, 32'(m_rx));
        chk("ovf_no_wr", 32'(mon_q.size()), 32'd0);
        tbr = 1'b1;
        cp = -1;
        for (int k = 0; k < DEPTH; k++) begin
            e = mq.pop_front();
            expect_acc("drain_wr", 1'b0, 2'b00, e, c0);
            if (k > 0) chk("drain_spacing", 32'(c0 - cp), 32'd3);
            cp = c0;
        end

        // Receive wins over transmit when both are ready
        tbr = 1'b0;
        repeat (3) tick();
        b = 8'($urandom);
        send(b, 1'b0, 2'b00);
        model_rx(b);
        expect_acc("arb_pre_rd", 1'b1, 2'b00, b, c0);
        repeat (3) tick();
        b2 = 8'($urandom);
        tbr = 1'b1;
        send(b2, 1'b0, 2'b00);
        expect_acc("arb_rd_first", 1'b1, 2'b00, b2, c0);
        model_rx(b2);
        e = mq.pop_front();
        expect_acc("arb_wr_second", 1'b0, 2'b00, e, c1);
        chk("arb_wr_gap", 32'(c1 - c0), 32'd3);
        e = mq.pop_front();
        expect_acc("arb_wr_third", 1'b0, 2'b00, e, c1);

        // Randomized traffic checked by replaying the bus log through the model
        repeat (5) tick();
        sent_q.delete();
        for (int i = 0; i < 12; i++) begin
            tbr = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            sent_q.push_back(b);
            send(b, 1'b0, 2'b00);
            repeat ($urandom_range(0, 3)) tick();
        end
        tbr = 1'b1;
        repeat (40) tick();
        while (mon_q.size() != 0) begin
            t = mon_q.pop_front();
            if (t.rw) begin
                b = (sent_q.size() != 0) ? sent_q.pop_front() : ~t.d;
                chk("rnd_rd", {22'd0, t.a, t.d}, {22'd0, 2'b00, b});
                model_rx(b);
            end else if (mq.size() != 0) begin
                e = mq.pop_front();
                chk("rnd_wr", {22'd0, t.a, t.d}, {22'd0, 2'b00, e});
            end else begin
                chk("rnd_wr_extra", {22'd0, t.a, t.d}, 32'hFFFF_FFFF);
            end
        end
        chk("rnd_all_sent", 32'(sent_q.size()), 32'd0);
        chk("rnd_fifo_drained", 32'(mq.size()), 32'd0);
        chk("rnd_rx_count", {24'd0, rx_count}, {24'd0, 8'(m_rx)});
        chk("rnd_ovf", {31'd0, ovf}, {31'd0, m_ovf});

        // Baud change during a read
        tbr = 1'b0;
        b = 8'($urandom);
        send(b, 1'b0, 2'b00);
        model_rx(b);
        expect_acc("baud_pre_rd", 1'b1, 2'b00, b, c0);
        repeat (3) tick();
        b2 = 8'($urandom);
        send(b2, 1'b1, 2'b11);
        model_rx(b2);
        expect_acc("baud_rd", 1'b1, 2'b00, b2, c0);
        expect_acc("baud_cfg_lo", 1'b0, 2'b10, div_tab[3][7:0], c1);
        chk("baud_cfg_lo_cycle", 32'(c1 - c0), 32'd3);
        expect_acc("baud_cfg_hi", 1'b0, 2'b11, div_tab[3][15:8], c1);
        chk("baud_cfg_hi_cycle", 32'(c1 - c0), 32'd4);
        tbr = 1'b1;
        e = mq.pop_front();
        expect_acc("baud_echo1", 1'b0, 2'b00, e, c1);
        e = mq.pop_front();
        expect_acc("baud_echo2", 1'b0, 2'b00, e, c1);

        // Reset in the middle of a write
        tbr = 1'b0;
        repeat (3) tick();
        b = 8'($urandom);
        send(b, 1'b0, 2'b00);
        model_rx(b);
        expect_acc("rstwr_rd", 1'b1, 2'b00, b, c0);
        repeat (3) tick();
        tbr = 1'b1;
        c0 = 0;
        while (!(iocs && !iorw && ioaddr == 2'b00) && c0 < 60) begin
            @(negedge clk);
            c0++;
        end
        rst = 1'b0;
        tick();
        chk("rstwr_iocs", {31'd0, iocs}, 32'd0);
        chk("rstwr_iorw", {31'd0, iorw}, 32'd1);
        chk("rstwr_rx_count", {24'd0, rx_count}, 32'd0);
        chk("rstwr_ovf", {31'd0, ovf}, 32'd0);
        e = mq.pop_front();
        expect_acc("rstwr_wr", 1'b0, 2'b00, e, c0);
        mq.delete();
        m_rx = 0;
        m_ovf = 1'b0;
        mon_q.delete();
        rst = 1'b1;
        rel = cyc;
        expect_acc("rstwr_cfg_lo", 1'b0, 2'b10, div_tab[3][7:0], c0);
        chk("rstwr_cfg_lo_cycle", 32'(c0), 32'(rel + 1));
        expect_acc("rstwr_cfg_hi", 1'b0, 2'b11, div_tab[3][15:8], c1);
        repeat (15) tick();
        chk("rstwr_fifo_empty", 32'(mon_q.size()), 32'd0);
        chk("rstwr_rx_after", {24'd0, rx_count}, 32'(m_rx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
